// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] PC_INCR          = 32'(WORD_BYTES);
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetched word together with the byte address it was fetched from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO of fetched words.
// Flush has priority over push and pop. The head is read straight from
// storage, so it keeps its last contents when the queue drains.
module fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, drives the instruction memory address,
// buffers returned words in a prefetch queue and hands them to decode.
// Optional performance counters (FetchCount, StallCount) are built when
// IFU_PERF_CNT_EN is defined.
//
// state | meaning
// ------+-------------------------------------------------------------
// HALT  | no fetching; PC held; queued entries still drain to decode
// RUN   | one word pushed per cycle while the queue has (or frees) room
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstruction,
    output logic [31:0] OutPC
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic         push;
    logic         pop;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t q_wr;

    assign Address        = pc;
    assign OutValid       = !q_empty;
    assign OutInstruction = q_head.instr;
    assign OutPC          = q_head.pc;
    assign q_wr           = '{instr: Instruction, pc: pc};

    // A redirect blocks the pop so the head being redirected away from is never delivered.
    assign pop = !q_empty && OutReady && !Redirect;

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= HALT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and push decision; a redirect suppresses the push and never wakes a halted unit.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        if (Redirect) begin
            state_next = (state == RUN && Enable) ? RUN : HALT;
        end else begin
            case (state)
                HALT: begin
                    if (Enable) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!Enable) begin
                        state_next = HALT;
                    end else if (!q_full || pop) begin
                        push = 1'b1;
                    end
                end
                default: state_next = HALT;
            endcase
        end
    end

    // Program counter: redirect wins over sequential advance; wraps silently at 2^32.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc <= align_pc(RESET_PC);
        end else if (Redirect) begin
            pc <= align_pc(RedirectPC);
        end else if (push) begin
            pc <= pc + PC_INCR;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk      (Clk),
        .rst      (Rst),
        .flush    (Redirect),
        .push     (push),
        .pop      (pop),
        .wr_entry (q_wr),
        .head     (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );

`ifdef IFU_PERF_CNT_EN
    logic stall;

    // A stall is a cycle where fetching was wanted but the queue had no room.
    assign stall = (state == RUN) && Enable && !Redirect && q_full && !pop;

    // Fetch and stall counters; survive redirects, clear only on reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            if (push) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (stall) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the PC and drives a word address to the combinational-read instruction memory each cycle.
- Captures the returned word into a small prefetch queue and hands {instruction, PC} to decode with a valid/ready handshake.
- Handles decode back-pressure, branch/jump redirects (with queue flush) and a fetch enable.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch queue entries; power of two, 2..8.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Enable  in  1  1 = fetching permitted; 0 = hold PC, no new pushes.
- Address  out  32  byte address to instruction memory; equals the PC register (combinational from state).
- Instruction  in  32  word returned by memory for Address, valid in the same cycle.
- Redirect  in  1  1 = discard queue and restart fetch at RedirectPC.
- RedirectPC  in  32  new PC; bits [1:0] are ignored (forced to 0).
- OutValid  out  1  queue head holds a valid entry.
- OutReady  in  1  decode accepts the head this cycle.
- OutInstruction  out  32  instruction at queue head.
- OutPC  out  32  byte address of OutInstruction.

Behaviour:
- Reset: PC = RESET_PC, queue count = 0, state = HALT, OutValid = 0, OutInstruction = 0, OutPC = 0. Address = RESET_PC in the cycle after reset.
- FSM, two states:
  - HALT: no push, PC held. Go to RUN when Enable = 1 and Redirect = 0.
  - RUN: go to HALT when Enable = 0.
  - Redirect overrides the state-transition rules. The FSM stays in or enters RUN only if Enable = 1; otherwise it is in HALT.
- Pop: occurs when OutValid && OutReady.
- Push: occurs in RUN when Redirect = 0 and (count < DEPTH or pop this cycle).
  - Writes {Instruction, Address} into the tail and sets PC <= PC + 4.
  - Latency: the word at PC is visible on OutInstruction the cycle after the push (registered queue, no bypass).
- Full queue: PC held and Address stable until a slot frees. Simultaneous pop + push when full is permitted, and count is unchanged.
- Empty queue: OutValid = 0. OutInstruction and OutPC hold their last values; the bench must not check them while OutValid = 0.
- Redirect (highest priority):
  - Queue flushed (count <= 0, pointers reset) and PC <= {RedirectPC[31:2], 2'b00}.
  - No push and no pop that cycle; OutReady is ignored.
  - OutValid = 0 in the following cycle. The first redirected word appears 2 cycles after Redirect if OutReady and Enable are held.
- Redirect while in HALT: PC is still updated, the queue is still flushed, and the unit stays halted.
- PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag. The memory decodes Address[15:2] only, so aliasing above 64 KB is the software's responsibility.
- Enable deasserted mid-stream: queued entries keep draining to decode; only new pushes stop.
- Reset asserted mid-operation: overrides Redirect, push and pop in that cycle and restores the reset values above.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined:
  - Adds outputs FetchCount [31:0] (increments on each push) and StallCount [31:0] (increments each RUN cycle with no push because the queue is full).
  - Both counters clear on Rst, wrap at 2^32, and do not clear on Redirect.
- Undefined: neither port nor either counter exists; behaviour is otherwise identical.

Decomposition:
- Package ifu_pkg holds:
  - WORD_BYTES = 4 and the PC increment.
  - DEFAULT_RESET_PC.
  - Queue entry typedef {logic [31:0] instr; logic [31:0] pc}.
  - State enum {HALT, RUN}.
- Natural sub-module: fetch_queue.
  - DEPTH-entry synchronous FIFO with push, pop, flush, full and empty; flush has priority over push and pop.
  - instruction_fetch_unit holds the PC, the FSM and the push/pop logic.

Test Plan:
- Reset -> sequential fetch: Rst 1 cycle, then Enable = 1, OutReady = 1, memory words 0x11,0x22,0x33 at 0x0,0x4,0x8 -> OutValid = 1 from cycle 2; OutPC = 0x0,0x4,0x8 with matching OutInstruction on consecutive cycles.
- Back-pressure (DEPTH = 2): OutReady = 0 for 5 cycles -> queue holds PC 0x0 and 0x4; Address stays 0x8. Release OutReady -> 0x0, 0x4, 0x8 delivered in order with no loss or duplicate.
- Redirect with a full queue: Redirect = 1, RedirectPC = 0x107 -> next cycle OutValid = 0 and Address = 0x104; first output is OutPC = 0x104 two cycles after Redirect; stale 0x0/0x4 never appear.
- Redirect and pop in the same cycle: OutReady = 1 with Redirect = 1 -> head not consumed, queue empty next cycle, no entry delivered twice.
- Enable toggle + wrap: RESET_PC = 32'hFFFF_FFF8, Enable = 1 -> Address 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Enable = 0 -> Address frozen while 2 queued entries still drain.
- IFU_PERF_CNT_EN: 6 pushes and 3 full-stall cycles -> FetchCount = 6, StallCount = 3. Rst -> both 0.
